outmap_stager: RTL and testbench

// Byte-level staging buffer directly upstream of the compressor. Accepts bursts of output-

---
 rtl/outmap_stager.sv | 131 +++++++++++++
 tb/tb_outmap_stager.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/outmap_stager.sv
// Byte staging buffer feeding the compressor: circular byte store with a
// 16-byte oldest-first window, valid count (0-8), layer start/done pulses.
// Ports: clk, rst (sync, active-high); push side in_valid/in_data/in_num/
// in_ready; flush; compressor side outmap_data/outmap_data_valid_num/
// valid_taken_num; status start, done, take_err (sticky).
module outmap_stager #(
    parameter int IN_BYTES = 8,
    parameter int DEPTH    = 32,
    parameter int WIN      = 16,
    parameter int MAX_VLD  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [IN_BYTES-1:0][7:0] in_data,
    input  logic [3:0]               in_num,
    output logic                     in_ready,
    input  logic                     flush,
    output logic [WIN-1:0][7:0]      outmap_data,
    output logic [3:0]               outmap_data_valid_num,
    output logic                     start,
    input  logic [3:0]               valid_taken_num,
    output logic                     done,
    output logic                     take_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(IN_BYTES);

    localparam logic [3:0]    INB      = 4'(IN_BYTES);
    localparam logic [3:0]    MV       = 4'(MAX_VLD);
    localparam logic [CW-1:0] CMV      = CW'(MAX_VLD);
    localparam logic [CW-1:0] FREE_MAX = CW'(DEPTH - IN_BYTES);

    typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;

    state_t        state_q;
    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] rd_ptr_q, wr_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic          done_q, err_q;

    logic          num_ok, push, over;
    logic [CW-1:0] push_n;
    logic [3:0]    vnum, pop_n;
    logic [AW-1:0] wr_off [DEPTH];

    always_comb begin
        num_ok   = (in_num != 4'd0) && (in_num <= INB);
        // Readiness uses the registered count, so a same-cycle pop never
        // makes room for the push; DRAIN refuses all new bytes.
        in_ready = (state_q != DRAIN) && (count_q <= FREE_MAX);
        push     = in_valid && in_ready && num_ok;
        push_n   = push ? CW'(in_num) : '0;
        start    = push && (state_q == IDLE);

        // STREAM releases only whole 8-byte groups; partial tails wait
        // for more data or for DRAIN.
        if (count_q >= CMV)
            vnum = MV;
        else if (state_q == DRAIN)
            vnum = count_q[3:0];
        else
            vnum = 4'd0;

        over    = valid_taken_num > vnum;
        pop_n   = over ? vnum : valid_taken_num;
        count_d = count_q + push_n - CW'(pop_n);

        for (int i = 0; i < WIN; i++) begin
            if (CW'(i) < count_q)
                outmap_data[i] = mem_q[rd_ptr_q + AW'(i)];
            else
                outmap_data[i] = 8'h00;
        end

        // Distance of each slot past the write pointer selects its byte.
        for (int j = 0; j < DEPTH; j++)
            wr_off[j] = AW'(j) - wr_ptr_q;
    end

    assign outmap_data_valid_num = vnum;
    assign done                  = done_q;
    assign take_err              = err_q;

    always_ff @(posedge clk) begin
        for (int j = 0; j < DEPTH; j++) begin
            if (push && (wr_off[j] < AW'(in_num)))
                mem_q[j] <= in_data[wr_off[j][IW-1:0]];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_q + AW'(pop_n);
            wr_ptr_q <= wr_ptr_q + AW'(push_n);
            count_q  <= count_d;
            done_q   <= 1'b0;
            if (over)
                err_q <= 1'b1;
            unique case (state_q)
                IDLE: begin
                    if (push)
                        state_q <= flush ? DRAIN : STREAM;
                    else if (flush)
                        done_q <= 1'b1;
                end
                STREAM: begin
                    if (flush)
                        state_q <= DRAIN;
                end
                DRAIN: begin
                    if (count_d == '0) begin
                        state_q <= IDLE;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_outmap_stager.sv
// Testbench for outmap_stager: directed vector table, hand sequences for
// full/wrap, take error, reset and idle flush, then random vs a queue model.
module tb_outmap_stager;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic [7:0][7:0]  in_data = '0;
    logic [3:0]       in_num = '0;
    logic             in_ready;
    logic             flush = 1'b0;
    logic [15:0][7:0] outmap_data;
    logic [3:0]       vnum;
    logic             start;
    logic [3:0]       valid_taken_num = '0;
    logic             done;
    logic             take_err;

    always #5 clk = ~clk;

    outmap_stager dut (
        .clk                   (clk),
        .rst                   (rst),
        .in_valid              (in_valid),
        .in_data               (in_data),
        .in_num                (in_num),
        .in_ready              (in_ready),
        .flush                 (flush),
        .outmap_data           (outmap_data),
        .outmap_data_valid_num (vnum),
        .start                 (start),
        .valid_taken_num       (valid_taken_num),
        .done                  (done),
        .take_err              (take_err)
    );

    int errors = 0;
    int checks = 0;

    // Reference: byte queue (front = oldest), phase 0 idle/1 stream/2 drain.
    byte unsigned q[$];
    int           mstate;
    bit           mdone;
    bit           merr;

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int m_vnum();
        int s;
        s = q.size();
        if (mstate == 2)
            return (s >= 8) ? 8 : s;
        return (s >= 8) ? 8 : 0;
    endfunction

    function automatic bit m_ready();
        return (mstate != 2) && (32 - q.size() >= 8);
    endfunction

    function automatic bit m_push();
        return in_valid && m_ready() && in_num >= 1 && in_num <= 8;
    endfunction

    function automatic logic [7:0][7:0] mkseq(int s);
        logic [7:0][7:0] r;
        for (int i = 0; i < 8; i++)
            r[i] = 8'(s + i);
        return r;
    endfunction

    task automatic check_model();
        logic [127:0] exp_w;
        exp_w = '0;
        for (int i = 0; i < 16; i++)
            if (i < q.size())
                exp_w[i*8 +: 8] = q[i];
        chk("in_ready", int'(in_ready), int'(m_ready()));
        chk("valid_num", int'(vnum), m_vnum());
        chk("start", int'(start), int'(m_push() && mstate == 0));
        chk("done", int'(done), int'(mdone));
        chk("take_err", int'(take_err), int'(merr));
        checks++;
        if (outmap_data !== exp_w) begin
            errors++;
            $display("FAIL window: got %h expected %h at %0t", outmap_data, exp_w, $time);
        end
    endtask

    task automatic drive(bit v, logic [7:0][7:0] d, int n, bit f, int t);
        @(negedge clk);
        in_valid        = v;
        in_data         = d;
        in_num          = 4'(n);
        flush           = f;
        valid_taken_num = 4'(t);
        #1;
    endtask

    task automatic advance();
        int  vn, pop, t;
        bit  p, nd;
        vn = m_vnum();
        p  = m_push();
        t  = int'(valid_taken_num);
        pop = (t > vn) ? vn : t;
        if (t > vn)
            merr = 1'b1;
        repeat (pop) void'(q.pop_front());
        if (p)
            for (int i = 0; i < int'(in_num); i++)
                q.push_back(in_data[i]);
        nd = 1'b0;
        case (mstate)
            0: if (p) mstate = flush ? 2 : 1;
               else if (flush) nd = 1'b1;
            1: if (flush) mstate = 2;
            default: if (q.size() == 0) begin
                mstate = 0;
                nd = 1'b1;
            end
        endcase
        mdone = nd;
        @(posedge clk);
    endtask

    task automatic cycle(bit v, logic [7:0][7:0] d, int n, bit f, int t);
        drive(v, d, n, f, t);
        check_model();
        advance();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst             = 1'b1;
        in_valid        = 1'b0;
        in_num          = '0;
        flush           = 1'b0;
        valid_taken_num = '0;
        @(posedge clk);
        q.delete();
        mstate = 0;
        mdone  = 1'b0;
        merr   = 1'b0;
        #1 rst = 1'b0;
    endtask

    typedef struct {
        bit v; int n; bit f; int t;
        bit rdy; int vn; bit st; bit dn; int w0; int w5;
    } vec_t;

    vec_t tbl[9];

    initial begin
        int nb;
        int vn, t;
        logic [7:0][7:0] d;

        tbl[0] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 0};
        tbl[1] = '{1, 8, 0, 0, 1, 0, 1, 0, 0, 0};
        tbl[2] = '{0, 0, 0, 3, 1, 8, 0, 0, 0, 5};
        tbl[3] = '{1, 8, 0, 0, 1, 0, 0, 0, 3, 0};
        tbl[4] = '{0, 0, 0, 8, 1, 8, 0, 0, 3, 8};
        tbl[5] = '{0, 0, 1, 0, 1, 0, 0, 0, 11, 0};
        tbl[6] = '{0, 0, 0, 5, 0, 5, 0, 0, 11, 0};
        tbl[7] = '{0, 0, 0, 0, 1, 0, 0, 1, 0, 0};
        tbl[8] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 0};

        do_reset();
        repeat (5) cycle(0, '0, 0, 0, 0);

        // Directed table: push 8, take 3, push 8, take 8, flush, drain.
        nb = 0;
        for (int k = 0; k < 9; k++) begin
            drive(tbl[k].v, mkseq(nb), tbl[k].n, tbl[k].f, tbl[k].t);
            if (tbl[k].v)
                nb += tbl[k].n;
            chk($sformatf("tbl%0d.ready", k), int'(in_ready), int'(tbl[k].rdy));
            chk($sformatf("tbl%0d.vnum", k), int'(vnum), tbl[k].vn);
            chk($sformatf("tbl%0d.start", k), int'(start), int'(tbl[k].st));
            chk($sformatf("tbl%0d.done", k), int'(done), int'(tbl[k].dn));
            chk($sformatf("tbl%0d.w0", k), int'(outmap_data[0]), tbl[k].w0);
            chk($sformatf("tbl%0d.w5", k), int'(outmap_data[5]), tbl[k].w5);
            check_model();
            advance();
        end

        // Fill to 32, then pop/push across pointer wrap.
        do_reset();
        for (int k = 0; k < 3; k++)
            cycle(1, mkseq(16 * k), 8, 0, 0);
        drive(1, mkseq(48), 8, 0, 0);
        chk("ready_at_24", int'(in_ready), 1);
        check_model();
        advance();
        drive(1, mkseq(64), 8, 0, 0);
        chk("ready_at_32", int'(in_ready), 0);
        check_model();
        advance();
        for (int k = 0; k < 14; k++)
            cycle(1, mkseq(80 + 8 * k), 8, 0, 8);
        for (int k = 0; k < 10; k++)
            cycle(1, mkseq(200 + 5 * k), 5, 0, (k % 2) ? 8 : 3);

        // Over-take sets sticky error, only 8 retired.
        do_reset();
        cycle(1, mkseq(100), 8, 0, 0);
        cycle(0, '0, 0, 0, 9);
        drive(0, '0, 0, 0, 0);
        chk("err_sticky", int'(take_err), 1);
        chk("vnum_after_over", int'(vnum), 0);
        check_model();
        advance();
        cycle(0, '0, 0, 1, 0);
        cycle(0, '0, 0, 0, 0);
        cycle(0, '0, 0, 0, 0);

        // Reset with 20 bytes buffered, then flush while idle.
        do_reset();
        cycle(1, mkseq(1), 8, 0, 0);
        cycle(1, mkseq(9), 8, 0, 0);
        cycle(1, mkseq(17), 4, 0, 0);
        do_reset();
        drive(0, '0, 0, 0, 0);
        chk("rst_vnum", int'(vnum), 0);
        chk("rst_ready", int'(in_ready), 1);
        chk("rst_done", int'(done), 0);
        chk("rst_w0", int'(outmap_data[0]), 0);
        check_model();
        advance();
        cycle(0, '0, 0, 1, 0);
        drive(0, '0, 0, 0, 0);
        chk("idle_flush_done", int'(done), 1);
        check_model();
        advance();
        cycle(0, '0, 0, 0, 0);

        // Random traffic against the queue model.
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            if ($urandom % 400 == 0)
                do_reset();
            vn = m_vnum();
            if ($urandom % 12 == 0)
                t = int'($urandom % 16);
            else
                t = int'($urandom_range(0, vn));
            d = {$urandom, $urandom};
            cycle(($urandom % 4) != 0, d, int'($urandom % 10),
                  ($urandom % 50) == 0, t);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
